cpu_multicycle: RTL and testbench

- Parametrised multi-cycle successor of the single-cycle 8-bit CPU core: same 32-bit instruction format and opcodes 0-11, plus new opcodes for bne and shifts.
- Generic data width and register count.
- FSM-sequenced datapath with busywait handshakes to both instruction memory and data memory.
- Sits between instruction cache/memory and data cache/memory at top level.

---
 rtl/cpu_multicycle.sv | 196 +++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB CPU core with busywait memory handshakes.
// Optional CPU_ILLEGAL_HALT_EN: unknown opcodes stop the core in HALT instead of acting as nop.
module cpu_multicycle #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    input  logic              IBUSYWAIT,
    output logic [PC_W-1:0]   PC,
    output logic              IREAD,
    input  logic [DATA_W-1:0] READDATA,
    input  logic              BUSYWAIT,
    output logic              READ,
    output logic              WRITE,
    output logic [DATA_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] WRITEDATA,
    output logic              HALTED
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [7:0] OP_LOADI = 8'd0,  OP_MOV = 8'd1,  OP_ADD = 8'd2,  OP_SUB = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4,  OP_OR  = 8'd5,  OP_J   = 8'd6,  OP_BEQ = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8,  OP_LWI = 8'd9,  OP_SWD = 8'd10, OP_SWI = 8'd11;
    localparam logic [7:0] OP_BNE   = 8'd12, OP_SLL = 8'd13, OP_SRL = 8'd14, OP_SRA = 8'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
`ifdef CPU_ILLEGAL_HALT_EN
        S_HALT,
`endif
        S_WB
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, mdr_q, mdr_d;
    logic              taken_q, taken_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];

    logic [7:0]        op, shamt;
    logic [RW-1:0]     dst, src1, src2;
    logic [PC_W-1:0]   off_ext, pc_seq, pc_branch;
    logic [DATA_W-1:0] diff, alu;
    logic              is_load, is_store, is_mem, illegal, reg_we, taken;
    logic              unused_fields;

    assign op        = ir_q[31:24];
    assign dst       = ir_q[16 +: RW];
    assign src1      = ir_q[8 +: RW];
    assign src2      = ir_q[0 +: RW];
    assign shamt     = ir_q[7:0];
    assign unused_fields = ^ir_q;

    assign is_load   = (op == OP_LWD) || (op == OP_LWI);
    assign is_store  = (op == OP_SWD) || (op == OP_SWI);
    assign is_mem    = is_load || is_store;
    assign illegal   = (op > OP_SRA);
    assign reg_we    = (op <= OP_OR) || is_load || (op >= OP_SLL && op <= OP_SRA);

    // Branch offset counts words relative to the following instruction.
    assign off_ext   = PC_W'($signed(ir_q[23:16]));
    assign pc_seq    = pc_q + PC_W'(4);
    assign pc_branch = pc_seq + (off_ext << 2);
    assign diff      = a_q - b_q;

    always_comb begin
        alu   = '0;
        taken = 1'b0;
        case (op)
            OP_LOADI: alu = imm_q;
            OP_MOV:   alu = a_q;
            OP_ADD:   alu = a_q + b_q;
            OP_SUB:   alu = diff;
            OP_AND:   alu = a_q & b_q;
            OP_OR:    alu = a_q | b_q;
            OP_J:     begin alu = diff; taken = 1'b1; end
            OP_BEQ:   begin alu = diff; taken = (diff == '0); end
            OP_BNE:   begin alu = diff; taken = (diff != '0); end
            OP_LWD, OP_SWD: alu = b_q;
            OP_LWI, OP_SWI: alu = imm_q;
            OP_SLL:   alu = a_q << shamt;
            OP_SRL:   alu = a_q >> shamt;
            OP_SRA:   alu = $unsigned($signed(a_q) >>> shamt);
            default:  alu = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        taken_d = taken_q;
        rf_d    = rf_q;
        case (state_q)
            S_FETCH: begin
                if (!IBUSYWAIT) begin
                    ir_d    = INSTRUCTION;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[src1];
                b_d     = rf_q[src2];
                imm_d   = DATA_W'(ir_q[7:0]);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                addr_d  = alu;
                wdata_d = a_q;
                taken_d = taken;
                if (is_mem)
                    state_d = S_MEM;
`ifdef CPU_ILLEGAL_HALT_EN
                else if (illegal)
                    state_d = S_HALT;
`endif
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (!BUSYWAIT) begin
                    if (is_load)
                        mdr_d = READDATA;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (reg_we && !illegal)
                    rf_d[dst] = is_load ? mdr_q : addr_q;
                pc_d    = taken_q ? pc_branch : pc_seq;
                state_d = S_FETCH;
            end
`ifdef CPU_ILLEGAL_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            taken_q <= 1'b0;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
            taken_q <= taken_d;
            rf_q    <= rf_d;
        end
    end

    // Requests are masked by RESET so they read 0 for the whole reset cycle.
    assign PC        = pc_q;
    assign IREAD     = (state_q == S_FETCH) && !RESET;
    assign READ      = (state_q == S_MEM) && is_load && !RESET;
    assign WRITE     = (state_q == S_MEM) && is_store && !RESET;
    assign ADDRESS   = addr_q;
    assign WRITEDATA = wdata_q;
`ifdef CPU_ILLEGAL_HALT_EN
    assign HALTED    = (state_q == S_HALT);
`else
    assign HALTED    = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - directed self-checking bench for cpu_multicycle.
module tb_cpu_multicycle;
    logic        CLK = 1'b0;
    logic        RESET, IBUSYWAIT, BUSYWAIT;
    logic [31:0] INSTRUCTION, PC;
    logic        IREAD, READ, WRITE, HALTED;
    logic [7:0]  READDATA, ADDRESS, WRITEDATA;

    logic [31:0] imem [64];
    logic [7:0]  dmem [256];
    int          n_pass = 0;
    int          n_total = 0;

    cpu_multicycle #(.DATA_W(8), .NREG(8), .PC_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IBUSYWAIT(IBUSYWAIT),
        .PC(PC), .IREAD(IREAD), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    assign INSTRUCTION = imem[PC[7:2]];
    assign READDATA    = dmem[ADDRESS];

    always @(posedge CLK)
        if (WRITE && !BUSYWAIT && !RESET)
            dmem[ADDRESS] <= WRITEDATA;

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_imem;
        for (int i = 0; i < 64; i++) imem[i] = ins(8'd6, 8'hFF, 8'd0, 8'd0);
    endtask

    task automatic pulse_reset;
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; IBUSYWAIT = 1'b0; BUSYWAIT = 1'b0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'hAA;
        clear_imem();
        imem[0]  = ins(8'd0,  8'd1, 8'd0, 8'h7F);  // loadi r1,0x7F
        imem[1]  = ins(8'd0,  8'd2, 8'd0, 8'h02);  // loadi r2,0x02
        imem[2]  = ins(8'd2,  8'd3, 8'd1, 8'd2);   // add r3,r1,r2
        imem[3]  = ins(8'd3,  8'd4, 8'd2, 8'd1);   // sub r4,r2,r1
        imem[4]  = ins(8'd11, 8'd0, 8'd3, 8'h20);  // swi r3,0x20
        imem[5]  = ins(8'd9,  8'd5, 8'd0, 8'h20);  // lwi r5,0x20
        imem[6]  = ins(8'd11, 8'd0, 8'd5, 8'h40);
        imem[7]  = ins(8'd11, 8'd0, 8'd4, 8'h41);
        imem[8]  = ins(8'd15, 8'd6, 8'd3, 8'd1);   // sra r6,r3,1
        imem[9]  = ins(8'd11, 8'd0, 8'd6, 8'h42);
        imem[10] = ins(8'd14, 8'd7, 8'd3, 8'd9);   // srl r7,r3,9
        imem[11] = ins(8'd11, 8'd0, 8'd7, 8'h43);
        imem[12] = ins(8'd15, 8'd6, 8'd3, 8'd9);   // sra r6,r3,9
        imem[13] = ins(8'd11, 8'd0, 8'd6, 8'h44);
        imem[14] = ins(8'd13, 8'd7, 8'd3, 8'd0);   // sll r7,r3,0
        imem[15] = ins(8'd11, 8'd0, 8'd7, 8'h45);
        imem[16] = ins(8'd2,  8'd1, 8'd1, 8'd1);   // add r1,r1,r1
        imem[17] = ins(8'd11, 8'd0, 8'd1, 8'h46);

        tick(1);
        chk("rst_pc", PC, 32'h0);
        chk("rst_iread", IREAD, 1'b0);
        chk("rst_read", READ, 1'b0);
        chk("rst_write", WRITE, 1'b0);
        chk("rst_halted", HALTED, 1'b0);
        chk("rst_address", ADDRESS, 8'h00);
        chk("rst_writedata", WRITEDATA, 8'h00);
        RESET = 1'b0;
        #1;
        chk("fetch_iread", IREAD, 1'b1);

        tick(3);  chk("loadi_pc_hold", PC, 32'h0);
        tick(1);  chk("loadi_pc", PC, 32'h4);
        tick(4);  chk("loadi2_pc", PC, 32'h8);
        tick(4);  chk("add_pc", PC, 32'hC);
        tick(4);  chk("sub_pc", PC, 32'h10);

        BUSYWAIT = 1'b1;
        tick(3);
        chk("swi_write", WRITE, 1'b1);
        chk("swi_addr", ADDRESS, 8'h20);
        chk("swi_wdata", WRITEDATA, 8'h81);
        tick(3);
        chk("swi_write_wait", WRITE, 1'b1);
        chk("swi_pc_wait", PC, 32'h10);
        BUSYWAIT = 1'b0;
        tick(1);
        chk("swi_write_drop", WRITE, 1'b0);
        chk("swi_mem", dmem[8'h20], 8'h81);
        tick(1);  chk("swi_pc", PC, 32'h14);

        tick(3);  chk("lwi_read", READ, 1'b1);
        tick(1);  chk("lwi_pc_hold", PC, 32'h14);
        tick(1);  chk("lwi_pc", PC, 32'h18);
        tick(5);  chk("lwi_r5", dmem[8'h40], 8'h81);
        tick(5);  chk("sub_r4", dmem[8'h41], 8'h83);
        tick(9);  chk("sra1", dmem[8'h42], 8'hC0);
        tick(9);  chk("srl9", dmem[8'h43], 8'h00);
        tick(9);  chk("sra9", dmem[8'h44], 8'hFF);
        tick(9);  chk("sll0", dmem[8'h45], 8'h81);
        chk("shift_pc", PC, 32'h40);
        tick(9);  chk("add_self", dmem[8'h46], 8'hFE);

        clear_imem();
        imem[0] = ins(8'd0,  8'd1, 8'd0, 8'h05);   // loadi r1,5
        imem[1] = ins(8'd0,  8'd2, 8'd0, 8'h05);   // loadi r2,5
        imem[2] = ins(8'd7,  8'h02, 8'd1, 8'd2);   // beq r1,r2,+2
        imem[5] = ins(8'd12, 8'h02, 8'd1, 8'd2);   // bne r1,r2,+2
        imem[6] = ins(8'd12, 8'h01, 8'd1, 8'd3);   // bne r1,r3,+1
        imem[8] = ins(8'd7,  8'h05, 8'd1, 8'd3);   // beq r1,r3,+5
        imem[9] = ins(8'd6,  8'hFF, 8'd0, 8'd0);   // j self
        pulse_reset();
        tick(8);  chk("br_setup_pc", PC, 32'h08);
        tick(4);  chk("beq_taken", PC, 32'h14);
        tick(4);  chk("bne_not_taken", PC, 32'h18);
        tick(4);  chk("bne_taken", PC, 32'h20);
        tick(4);  chk("beq_not_taken", PC, 32'h24);
        tick(4);  chk("j_self", PC, 32'h24);
        tick(4);  chk("j_self2", PC, 32'h24);

        clear_imem();
        imem[0] = ins(8'd0,  8'd1, 8'd0, 8'h33);
        imem[1] = ins(8'h20, 8'd1, 8'd1, 8'd1);    // unknown opcode
        imem[2] = ins(8'd11, 8'd0, 8'd1, 8'h50);
        pulse_reset();
        tick(4);  chk("ill_setup_pc", PC, 32'h04);
        tick(4);
`ifdef CPU_ILLEGAL_HALT_EN
        chk("ill_halted", HALTED, 1'b1);
        chk("ill_pc_frozen", PC, 32'h04);
        chk("ill_no_iread", IREAD, 1'b0);
        tick(6);
        chk("ill_still_halted", PC, 32'h04);
`else
        chk("ill_nop_pc", PC, 32'h08);
        chk("ill_no_halt", HALTED, 1'b0);
        tick(5);
        chk("ill_no_reg_change", dmem[8'h50], 8'h33);
`endif

        clear_imem();
        imem[0] = ins(8'd0, 8'd1, 8'd0, 8'h11);
        imem[1] = ins(8'd0, 8'd2, 8'd0, 8'h22);
        imem[2] = ins(8'd0, 8'd3, 8'd0, 8'h33);
        imem[3] = ins(8'd0, 8'd4, 8'd0, 8'h44);
        pulse_reset();
        tick(16); chk("mid_setup_pc", PC, 32'h10);
        IBUSYWAIT = 1'b1;
        tick(3);
        chk("ibusy_pc_hold", PC, 32'h10);
        chk("ibusy_iread", IREAD, 1'b1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_iread", IREAD, 1'b0);
        for (int i = 0; i < 4; i++) imem[i] = ins(8'd11, 8'd0, 8'(i + 1), 8'(8'h60 + i));
        tick(1);
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_iread_hold", IREAD, 1'b0);
        RESET = 1'b0; IBUSYWAIT = 1'b0;
        #1;
        chk("mid_fetch_iread", IREAD, 1'b1);
        tick(20);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_reg_r%0d", i + 1), dmem[8'h60 + i], 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
